instr_fetch: RTL and testbench

Instruction fetch unit for the 8-bit CPU: the reading side of the 32-byte program ROM. It owns the program counter, drives the ROM address/read strobe, assembles 1-byte and 3-byte instructions (opcode, operand low, operand high), and presents each complete instruction to the decoder with a valid/ready handshake. The decoder redirects it on taken jumps.

---
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads the program ROM byte by byte and
// presents assembled 1- or 3-byte instructions to the decoder over valid/ready.
module instr_fetch #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read,
  input  logic [7:0]        rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [15:0]       instr_operand,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_illegal,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr
);

  typedef enum logic [2:0] {
    StIdle,
    StFetchOp,
    StFetchLo,
    StFetchHi,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [7:0]        opcode_q, opcode_d;
  logic [15:0]       operand_q, operand_d;
  logic [1:0]        len_q, len_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              is_long;

  // Wraps naturally modulo 2^ADDR_W, so operands may straddle the top of ROM.
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign is_long = rom_data inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h07};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    ipc_d     = ipc_q;

    unique case (state_q)
      StIdle: state_d = StFetchOp;
      StFetchOp: begin
        opcode_d  = rom_data;
        ipc_d     = pc_q;
        operand_d = 16'h0000;
        pc_d      = pc_inc;
        if (is_long) begin
          len_d   = 2'd3;
          state_d = StFetchLo;
        end else begin
          len_d   = 2'd1;
          state_d = StHold;
        end
      end
      StFetchLo: begin
        operand_d[7:0] = rom_data;
        pc_d           = pc_inc;
        state_d        = StFetchHi;
      end
      StFetchHi: begin
        operand_d[15:8] = rom_data;
        pc_d            = pc_inc;
        state_d         = StHold;
      end
      StHold: begin
        if (instr_ready) begin
          state_d = StFetchOp;
        end
      end
      default: state_d = StIdle;
    endcase

    // A jump overrides everything; a coincident handshake is simply absorbed.
    if (redirect_valid && (state_q != StIdle)) begin
      pc_d    = redirect_addr;
      state_d = StFetchOp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      opcode_q  <= 8'h00;
      operand_q <= 16'h0000;
      len_q     <= 2'd0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      ipc_q     <= ipc_d;
    end
  end

  assign rom_addr      = pc_q;
  assign rom_read      = (state_q == StFetchOp) || (state_q == StFetchLo) ||
                         (state_q == StFetchHi);
  assign instr_valid   = (state_q == StHold);
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign instr_len     = len_q;
  assign instr_pc      = ipc_q;
  assign instr_illegal = |opcode_q[7:4];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed programs push expected instructions,
// a monitor pops and compares each one as the decoder accepts it.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rom_addr;
  logic        rom_read;
  logic [7:0]  rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic [1:0]  instr_len;
  logic [4:0]  instr_pc;
  logic        instr_illegal;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;

  instr_fetch #(.ADDR_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_addr      (rom_addr),
    .rom_read      (rom_read),
    .rom_data      (rom_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_len     (instr_len),
    .instr_pc      (instr_pc),
    .instr_illegal (instr_illegal),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr)
  );

  typedef struct {
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [1:0]  len;
    logic [4:0]  pc;
    logic        ill;
    int          cyc;  // accept-sample cycle after reset release, -1 = don't care
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rom[32];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         t0       = 0;
  int         acc_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb rom_data = rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [15:0] opnd, input logic [1:0] len,
                          input logic [4:0] pc, input int c);
    exp_t e;
    e.op = op; e.opnd = opnd; e.len = len; e.pc = pc; e.ill = |op[7:4]; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: sample away from the active edge; valid & ready here means accepted next edge.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_instr_pc", {27'd0, instr_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("opcode", {24'd0, instr_opcode}, {24'd0, e.op});
        check("operand", {16'd0, instr_operand}, {16'd0, e.opnd});
        check("len", {30'd0, instr_len}, {30'd0, e.len});
        check("instr_pc", {27'd0, instr_pc}, {27'd0, e.pc});
        check("illegal", {31'd0, instr_illegal}, {31'd0, e.ill});
        if (e.cyc >= 0) check("accept_cycle", cyc - t0, e.cyc);
      end
    end
  end

  task automatic load_rom(input int which);
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    if (which == 1) begin
      rom[0] = 8'h01; rom[1] = 8'h0E; rom[2] = 8'h00; rom[3] = 8'h00; rom[4] = 8'h08;
      rom[20] = 8'h08;
    end else if (which == 2) begin
      rom[30] = 8'h06; rom[31] = 8'h10; rom[0] = 8'h00;
    end else if (which == 3) begin
      rom[0] = 8'h20;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_rom_read"}, {31'd0, rom_read}, 32'd0);
    check({tag, "_rom_addr"}, {27'd0, rom_addr}, 32'd0);
    check({tag, "_opcode_operand"}, {instr_opcode, instr_operand, 8'd0}, 32'd0);
    check({tag, "_len_pc_ill"}, {24'd0, instr_len, instr_pc, instr_illegal}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 5'd0;
    exp_q.delete();
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    acc_cnt = 0;
  endtask

  task automatic wait_acc(input int n);
    int k;
    k = 0;
    while (acc_cnt < n && k < 60) begin
      @(posedge clk);
      k++;
    end
    check("accept_timeout", (acc_cnt >= n) ? 32'd1 : 32'd0, 32'd1);
    #1 instr_ready = 1'b0;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!instr_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 5'd0;

    // 1: ldac then two 1-byte instructions with ready held high.
    load_rom(1);
    do_reset();
    instr_ready = 1'b1;
    push_exp(8'h01, 16'h000E, 2'd3, 5'd0, 4);
    push_exp(8'h00, 16'h0000, 2'd1, 5'd3, 6);
    push_exp(8'h08, 16'h0000, 2'd1, 5'd4, 8);
    wait_acc(3);

    // 2: decoder stalls for 5 cycles on the first instruction.
    do_reset();
    instr_ready = 1'b0;
    push_exp(8'h01, 16'h000E, 2'd3, 5'd0, -1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_opcode", {24'd0, instr_opcode}, 32'h01);
      check("stall_operand", {16'd0, instr_operand}, 32'h000E);
      check("stall_rom_read", {31'd0, rom_read}, 32'd0);
      check("stall_pc", {27'd0, rom_addr}, 32'd3);
      @(negedge clk);
    end
    @(posedge clk);
    #1 instr_ready = 1'b1;
    wait_acc(1);
    @(negedge clk);
    check("post_stall_addr", {27'd0, rom_addr}, 32'd3);
    check("post_stall_read", {31'd0, rom_read}, 32'd1);

    // 3: redirect to 20 during FETCH_LO of the ldac at 0.
    do_reset();
    instr_ready = 1'b1;
    push_exp(8'h08, 16'h0000, 2'd1, 5'd20, 4);
    @(posedge clk);
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_addr = 5'd20;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_addr", {27'd0, rom_addr}, 32'd20);
    check("redir_read", {31'd0, rom_read}, 32'd1);
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    wait_acc(1);

    // 4: redirect to 30, jmpz operand straddles the wrap.
    load_rom(2);
    do_reset();
    instr_ready = 1'b0;
    push_exp(8'h06, 16'h0010, 2'd3, 5'd30, -1);
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_addr = 5'd30;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    wait_valid();
    check("wrap_pc_after", {27'd0, rom_addr}, 32'd1);
    @(posedge clk);
    #1 instr_ready = 1'b1;
    wait_acc(1);

    // 5: illegal opcode is a 1-byte instruction.
    load_rom(3);
    do_reset();
    instr_ready = 1'b1;
    push_exp(8'h20, 16'h0000, 2'd1, 5'd0, 2);
    wait_acc(1);
    @(negedge clk);
    check("illegal_next_addr", {27'd0, rom_addr}, 32'd1);
    check("illegal_next_read", {31'd0, rom_read}, 32'd1);

    // 6: asynchronous reset during FETCH_HI, then refetch from 0.
    load_rom(1);
    do_reset();
    instr_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("async_rst");
    do_reset();
    instr_ready = 1'b1;
    push_exp(8'h01, 16'h000E, 2'd3, 5'd0, 4);
    wait_acc(1);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
